// File: rtl/rm_pkg.sv
// rtl/rm_pkg.sv - Reed-Muller encoder shared types and generator-row helpers
package rm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_DONE = 2'd2
    } rm_state_t;

    localparam int RM_MAX_M = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int rm_binom(input int n, input int k);
        int c;
        c = 1;
        for (int j = 0; j < k; j++) c = c * (n - j) / (j + 1);
        return c;
    endfunction

    function automatic int rm_k(input int m, input int r);
        int s;
        s = 0;
        for (int i = 0; i <= r; i++) s += rm_binom(m, i);
        return s;
    endfunction

    // Bit j-1 of the mask selects x_j. Scanning bit-reversed masks downward
    // within each degree yields lexicographic order by variable index.
    function automatic logic [RM_MAX_M-1:0] rm_row_subset(input int m, input int r, input int k);
        logic [RM_MAX_M-1:0] mask;
        logic [31:0]         vb;
        int                  idx;
        mask = '0;
        idx  = 0;
        for (int d = 0; d <= r; d++) begin
            for (int v = (1 << m) - 1; v >= 0; v--) begin
                vb = 32'(v);
                if ($countones(vb) == d) begin
                    if (idx == k) begin
                        for (int j = 0; j < m; j++) mask[j] = vb[m-1-j];
                    end
                    idx++;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/rm_lane_xor.sv
// rtl/rm_lane_xor.sv - combinational RM codeword slice: LANES positions from a base index
module rm_lane_xor
    import rm_pkg::*;
#(
    parameter int M     = 5,
    parameter int R     = 2,
    parameter int LANES = 32
) (
    input  logic [rm_k(M,R)-1:0] i_data,
    input  logic [M-1:0]         i_base,
    output logic [LANES-1:0]     o_bits
);

    localparam int K = rm_k(M, R);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [M-1:0] w_idx;
        logic [K-1:0] w_term;

        // base is always a multiple of LANES, so OR equals add here
        assign w_idx = i_base | M'(l);

        for (genvar k = 0; k < K; k++) begin : g_row
            localparam logic [M-1:0] MASK = M'(rm_row_subset(M, R, k));
            assign w_term[k] = i_data[k] & (&(w_idx | ~MASK));
        end

        assign o_bits[l] = ^w_term;
    end

endmodule

// File: rtl/rm_encoder_seq.sv
// rtl/rm_encoder_seq.sv - RM(R,M) encoder, LANES bits per beat, one word in flight
module rm_encoder_seq
    import rm_pkg::*;
#(
    parameter int M     = 5,
    parameter int R     = 2,
    parameter int LANES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [rm_k(M,R)-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(1<<M)-1:0]     out_cw,
    output logic                  busy
);

    localparam int N     = 1 << M;
    localparam int K     = rm_k(M, R);
    localparam int BEATS = N / LANES;
    localparam int CW    = (BEATS > 1) ? clog2(BEATS) : 1;

    if (M < 3 || M > RM_MAX_M || R < 0 || R > M || LANES < 1 || LANES > N ||
        (LANES & (LANES - 1)) != 0) begin : g_bad_params
        $error("rm_encoder_seq: illegal parameters M=%0d R=%0d LANES=%0d", M, R, LANES);
    end

    rm_state_t        r_state;
    rm_state_t        w_state_nxt;
    logic [CW-1:0]    r_beat;
    logic [K-1:0]     r_data;
    logic [N-1:0]     r_cw;
    logic [M-1:0]     w_base;
    logic [LANES-1:0] w_lane;
    logic             w_last;

    assign w_last = (r_beat == CW'(BEATS - 1));
    assign w_base = M'(r_beat) * M'(LANES);

    rm_lane_xor #(.M(M), .R(R), .LANES(LANES)) u_lane_xor (
        .i_data (r_data),
        .i_base (w_base),
        .o_bits (w_lane)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_data  <= '0;
            r_cw    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && in_valid) begin
                r_data <= in_data;
                r_beat <= '0;
            end
            if (r_state == ST_ENC) begin
                r_beat <= w_last ? '0 : r_beat + 1'b1;
                for (int b = 0; b < BEATS; b++) begin
                    if (r_beat == CW'(b)) r_cw[b*LANES +: LANES] <= w_lane;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_nxt = ST_ENC;
            end
            ST_ENC: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign out_cw = r_cw;

endmodule
